// File: rtl/coffee_pkg.sv
// Shared stage/coffee encodings and recipe table for the brew sequencer.
// next_stage() skips zero-duration stages so the FSM never spends a cycle in them.
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRIND    = 3'd1,
        ST_HEAT     = 3'd2,
        ST_BREW     = 3'd3,
        ST_MILK     = 3'd4,
        ST_DISPENSE = 3'd5,
        ST_DONE     = 3'd6
    } stage_t;

    typedef enum logic [1:0] {
        CF_ESPRESSO  = 2'd0,
        CF_AMERICANO = 2'd1,
        CF_LATTE     = 2'd2,
        CF_INVALID   = 2'd3
    } coffee_t;

    // Indexed [coffee][stage]; only GRIND..DISPENSE columns carry durations.
    localparam logic [7:0] RECIPE_DUR [0:3][0:7] = '{
        '{8'd0, 8'd3, 8'd2, 8'd4, 8'd0, 8'd2, 8'd0, 8'd0},
        '{8'd0, 8'd3, 8'd3, 8'd6, 8'd0, 8'd4, 8'd0, 8'd0},
        '{8'd0, 8'd3, 8'd2, 8'd4, 8'd5, 8'd3, 8'd0, 8'd0},
        '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}
    };

    function automatic logic [7:0] recipe_ticks(coffee_t sel, stage_t st);
        return RECIPE_DUR[int'(sel)][int'(st)];
    endfunction

    function automatic stage_t next_stage(stage_t cur, coffee_t sel);
        stage_t r;
        r = ST_DONE;
        for (int s = 5; s >= 1; s--) begin
            if (s > int'(cur) && RECIPE_DUR[int'(sel)][s] != 8'd0) begin
                r = stage_t'(3'(s));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter timing each stage; term_o flags the tick that ends it.
module stage_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] remaining_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign remaining_o = cnt_q;
    assign term_o      = tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/brew_sequencer.sv
// Recipe-driven coffee sequencer: walks timed stages on tick pulses and drives
// actuator enables decoded from the registered stage.
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int DONE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       coffee_sel,
    output logic [2:0]       stage,
    output logic [1:0]       active_sel,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic             grinder_en,
    output logic             heater_en,
    output logic             pump_en,
    output logic             milk_en
);

    stage_t           stage_q, stage_d;
    coffee_t          sel_q, sel_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             busy_w, accept_w, take_abort_w, term_w;
    logic             tmr_clear, tmr_load;
    logic [CNT_W-1:0] tmr_val;

    assign busy_w       = (stage_q != ST_IDLE);
    assign accept_w     = !busy_w && start && !abort && (coffee_sel != 2'd3);
    assign take_abort_w = busy_w && abort;

    always_comb begin
        stage_d   = stage_q;
        sel_d     = sel_q;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (take_abort_w) begin
            stage_d   = ST_IDLE;
            tmr_clear = 1'b1;
        end else if (accept_w) begin
            sel_d    = coffee_t'(coffee_sel);
            stage_d  = next_stage(ST_IDLE, coffee_t'(coffee_sel));
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(recipe_ticks(coffee_t'(coffee_sel), stage_d));
        end else if (busy_w && term_w) begin
            if (stage_q == ST_DONE) begin
                stage_d   = ST_IDLE;
                tmr_clear = 1'b1;
            end else begin
                stage_d  = next_stage(stage_q, sel_q);
                tmr_load = 1'b1;
                tmr_val  = (stage_d == ST_DONE) ? CNT_W'(DONE_TICKS)
                                                : CNT_W'(recipe_ticks(sel_q, stage_d));
            end
        end
        // Pulses are registered so they line up with the stage they describe.
        done_d    = (stage_d == ST_DONE) && (stage_q != ST_DONE);
        aborted_d = take_abort_w;
        err_d     = !busy_w && start && (coffee_sel == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= ST_IDLE;
            sel_q     <= CF_ESPRESSO;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    stage_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (tick),
        .remaining_o(remaining),
        .term_o     (term_w)
    );

    assign stage      = stage_q;
    assign active_sel = sel_q;
    assign busy       = busy_w;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign err        = err_q;
    assign grinder_en = (stage_q == ST_GRIND);
    assign heater_en  = (stage_q == ST_HEAT) || (stage_q == ST_BREW);
    assign pump_en    = (stage_q == ST_BREW) || (stage_q == ST_DISPENSE);
    assign milk_en    = (stage_q == ST_MILK);

endmodule
